ternary_mac_array: RTL
======================

// Module: ternary_mac_array
// PURPOSE
//  Parametrised H x W array for 1.58-bit (ternary) weights x signed 8-bit activations.
//  Each accepted beat: acc[i][j] += w[i] * a[j].
//  A beat flagged last snapshots all results into an output queue and clears the accumulators.
//  The queue drains one saturated, shifted byte per valid/ready handshake.
//  Sits between the tt_um top-level pin mux and the chip outputs; successor to the fixed 4x1 array.
// PARAMETERS
//  H      4   rows; ternary weights per beat
//  W      2   columns; 8-bit activation lanes per beat
//  ACC_W  17  accumulator width, two's complement
//  SH_W   4   width of cfg_shift
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        synchronous, active-low reset
//  in_valid    in   1        beat present
//  in_ready    out  1        beat accepted when in_valid & in_ready
//  in_weights  in   2*H      packed ternary; row i = bits [2i+1:2i]
//  in_act      in   8*W      signed activations; lane j = bits [8j+7:8j]
//  in_last     in   1        final beat of the current tile
//  cfg_shift   in   SH_W     arithmetic right shift applied at readout
//  out_valid   out  1        queue element present
//  out_ready   in   1        consumer takes element
//  out_data    out  8        shifted, saturated signed result
//  out_index   out  clog2(H*W)  element index, i*W+j
//  out_last    out  1        high on the final element (index H*W-1)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge) sets all acc and the queue to 0, the drain counter to 0, q_busy to 0.
//    Outputs after reset: out_valid=0, out_data=0, out_index=0, out_last=0.
//    A reset mid-tile or mid-drain discards all state; no partial output is emitted.
//  - Weight decode: 00 -> 0; 01 -> +1; 10 or 11 -> -1. Bit 2i+1 is the sign.
//  - MAC: on each accepted beat, acc += a, acc -= a, or acc is unchanged.
//    The activation is sign-extended to ACC_W. Overflow wraps; there is no saturation in acc.
//  - Tile end: on an accepted beat with in_last=1:
//    - queue[n] <= acc_next[n], i.e. that beat is included.
//    - All acc <= 0.
//    - cfg_shift is latched into sh_q.
//    - q_busy <= 1 and the drain counter <= 0.
//    out_valid rises on the next cycle, so tile-end-to-first-output latency is 1 cycle.
//  - Drain FSM, two states:
//    - IDLE: q_busy=0, out_valid=0.
//    - DRAIN: out_valid=1. Each out_valid & out_ready advances the index.
//      The handshake at index H*W-1 returns the FSM to IDLE unless a new snapshot lands in the same cycle.
//    - out_data, out_index and out_last are held stable while out_valid & !out_ready.
//  - Readout arithmetic: v = queue[idx] >>> sh_q.
//    out_data = v clamped to [-128, 127]: 0x80 if v < -128, 0x7F if v > 127.
//  - Back-pressure: in_ready = !q_busy | !in_last | (out_valid & out_ready & out_last).
//    Non-last beats are never stalled, so accumulation overlaps the drain.
//    in_ready depends combinationally on in_last, out_ready and out_last.
//  - Simultaneous final drain handshake and accepted last beat: the new snapshot wins.
//    The FSM stays in DRAIN with index 0; no idle cycle is inserted.
//  - in_valid=0 leaves acc unchanged.
//  - A tile of one beat (in_last on its first beat) is legal.
// CONFIGURATION
//  Macro TMAC_RELU_EN:
//  - Defined: negative v is forced to 0 before saturation, so out_data is in [0, 127].
//  - Undefined: signed saturation only, as above; no ReLU logic is instantiated.
// STRUCTURE
//  Package tmac_pkg:
//  - ternary encodings TRN_ZERO / TRN_POS / TRN_NEG
//  - function trn_decode (returns zero/sign)
//  - drain state enum (DRN_IDLE, DRN_DRAIN)
//  - function sat8 (ACC_W -> 8)
//  Sub-module tmac_cell:
//  - one accumulator plus add/sub/hold mux
//  - ports: clk, rst_n, en, clr, zero, sign, act, acc_next, acc
//  - instantiated H*W times by a generate loop
//  The queue, the drain FSM and the readout shifter stay in ternary_mac_array.
// TESTING
//  - H=4, W=2, shift=0. Weights +1,-1,0,+1 with act (5,-3) for 3 beats, last on beat 3.
//    -> out: 15,-9,-15,9,0,0,15,-9; out_last only on the 8th; out_valid 1 cycle after the last beat.
//  - act=127, all weights +1, 300 beats, shift=4.
//    -> acc=38100, v=2381, out=0x7F for every element; with TMAC_RELU_EN and weights -1 -> 0x00.
//  - Hold out_ready=0 for 5 cycles mid-drain.
//    -> out_data and out_index stable; non-last beats still accepted; a last beat stalls (in_ready=0).
//  - A last beat arrives on the same cycle as the final drain handshake.
//    -> next cycle: out_valid=1, out_index=0, new tile data; no bubble.
//  - rst_n=0 for 1 cycle mid-drain at index 3.
//    -> next cycle out_valid=0; a following 1-beat tile with w=+1, act=2 yields 2 (no residue).
//  - Accumulate to 65535+1 with ACC_W=17.
//    -> wraps to -65536 (two's complement); the shifted readout saturates to 0x80.

Source files
------------

// File: rtl/tmac_pkg.sv
// Shared definitions for the ternary MAC array.
// Contents:
//   TRN_ZERO / TRN_POS / TRN_NEG  ternary weight encodings (2'b11 also decodes as -1)
//   trn_t, trn_decode             weight code -> {zero, sign}
//   drn_state_e                   drain FSM states
//   sat8                          signed clamp to one byte
package tmac_pkg;

  localparam logic [1:0] TRN_ZERO = 2'b00;
  localparam logic [1:0] TRN_POS  = 2'b01;
  localparam logic [1:0] TRN_NEG  = 2'b10;

  typedef struct packed {
    logic zero;
    logic sign;
  } trn_t;

  typedef enum logic {
    DRN_IDLE  = 1'b0,
    DRN_DRAIN = 1'b1
  } drn_state_e;

  // The upper bit is the sign, so both 10 and 11 mean -1.
  function automatic trn_t trn_decode(input logic [1:0] w);
    trn_t r;
    r.zero = (w == TRN_ZERO);
    r.sign = w[1];
    return r;
  endfunction

  function automatic logic [7:0] sat8(input logic signed [31:0] v);
    logic [7:0] r;
    if (v < -32'sd128)     r = 8'h80;
    else if (v > 32'sd127) r = 8'h7F;
    else                   r = v[7:0];
    return r;
  endfunction

endpackage

// File: rtl/tmac_cell.sv
// One accumulator of the ternary MAC array.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   en          beat accepted this cycle
//   clr         accepted beat closes the tile; accumulator returns to 0
//   zero, sign  decoded ternary weight (hold / subtract / add)
//   act         signed 8-bit activation
//   acc_next    accumulator value including this beat (snapshot source)
//   acc         current accumulator value
module tmac_cell
  import tmac_pkg::*;
#(
  parameter int ACC_W = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    zero,
  input  logic                    sign,
  input  logic signed [7:0]       act,
  output logic signed [ACC_W-1:0] acc_next,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] acc_q, acc_d, act_ext;

  always_comb begin
    act_ext = {{(ACC_W-8){act[7]}}, act};
    // Wraps on overflow by construction; no saturation in the accumulator.
    if (zero)      acc_next = acc_q;
    else if (sign) acc_next = acc_q - act_ext;
    else           acc_next = acc_q + act_ext;
    acc_d = acc_q;
    if (en) acc_d = clr ? '0 : acc_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/ternary_mac_array.sv
// H x W array of ternary-weight x signed 8-bit activation accumulators with a
// snapshot queue drained one saturated, shifted byte per handshake.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   in_valid/in_ready        input beat handshake
//   in_weights [2H]          ternary weight per row
//   in_act [8W]              signed activation per column
//   in_last                  final beat of the tile (snapshot + clear)
//   cfg_shift [SH_W]         readout arithmetic right shift, latched at tile end
//   out_valid/out_ready      output element handshake
//   out_data [8]             shifted, saturated result
//   out_index                element index i*W+j
//   out_last                 final element of the snapshot
// Build option: define TMAC_RELU_EN to clamp negative results to 0 before saturation.
module ternary_mac_array
  import tmac_pkg::*;
#(
  parameter  int H     = 4,
  parameter  int W     = 2,
  parameter  int ACC_W = 17,
  parameter  int SH_W  = 4,
  localparam int N     = H * W,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*H-1:0]    in_weights,
  input  logic [8*W-1:0]    in_act,
  input  logic              in_last,
  input  logic [SH_W-1:0]   cfg_shift,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last
);

  drn_state_e              state_q, state_d;
  logic [IDX_W-1:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]         sh_q, sh_d;
  logic signed [ACC_W-1:0] queue_q [N];
  logic signed [ACC_W-1:0] queue_d [N];
  logic signed [ACC_W-1:0] acc_next_w [N];
  logic signed [ACC_W-1:0] acc_w [N];

  logic accept, snap, fin_hs;
  logic signed [ACC_W-1:0] v_sh;
  logic signed [31:0]      v_ext;

  assign out_valid = (state_q == DRN_DRAIN);
  assign out_last  = out_valid && (cnt_q == IDX_W'(N-1));
  assign out_index = cnt_q;
  assign fin_hs    = out_valid && out_ready && out_last;
  // A new snapshot may only land when the queue is free or being vacated this cycle.
  assign in_ready  = (state_q == DRN_IDLE) || !in_last || fin_hs;
  assign accept    = in_valid && in_ready;
  assign snap      = accept && in_last;

  for (genvar i = 0; i < H; i++) begin : g_row
    trn_t dec;
    assign dec = trn_decode(in_weights[2*i +: 2]);
    for (genvar j = 0; j < W; j++) begin : g_col
      tmac_cell #(.ACC_W(ACC_W)) u_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (accept),
        .clr      (snap),
        .zero     (dec.zero),
        .sign     (dec.sign),
        .act      (in_act[8*j +: 8]),
        .acc_next (acc_next_w[i*W+j]),
        .acc      (acc_w[i*W+j])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    queue_d = queue_q;
    if (out_valid && out_ready) begin
      if (out_last) begin
        state_d = DRN_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // A snapshot overrides the final handshake so back-to-back tiles have no bubble.
    if (snap) begin
      state_d = DRN_DRAIN;
      cnt_d   = '0;
      sh_d    = cfg_shift;
      for (int n = 0; n < N; n++) queue_d[n] = acc_next_w[n];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DRN_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      for (int n = 0; n < N; n++) queue_q[n] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      queue_q <= queue_d;
    end
  end

  always_comb begin
    v_sh  = queue_q[cnt_q] >>> sh_q;
    v_ext = 32'(v_sh);
`ifdef TMAC_RELU_EN
    if (v_ext < 0) v_ext = '0;
`endif
    out_data = out_valid ? sat8(v_ext) : 8'h00;
  end

endmodule
